// File: rtl/reaction_timer_if.sv
// reaction_timer_if: handshake between the light-sequence FSM and the reaction timer.
//   master (FSM side)   : drives en_lfsr, start_delay and react; receives the timer outputs.
//   slave  (timer side) : receives en_lfsr, start_delay and react; drives tick, time_out,
//                         react_ms[13:0], result_valid, false_start and busy.
interface reaction_timer_if;
   logic        en_lfsr;
   logic        start_delay;
   logic        react;
   logic        tick;
   logic        time_out;
   logic [13:0] react_ms;
   logic        result_valid;
   logic        false_start;
   logic        busy;

   modport master (
      output en_lfsr, start_delay, react,
      input  tick, time_out, react_ms, result_valid, false_start, busy
   );

   modport slave (
      input  en_lfsr, start_delay, react,
      output tick, time_out, react_ms, result_valid, false_start, busy
   );
endinterface

// File: rtl/reaction_timer.sv
// reaction_timer: random-delay and reaction-measurement engine.
//   clk   : single clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : reaction_timer_if.slave
//           en_lfsr      - advance the LFSR every clock while high
//           start_delay  - level; its rising edge arms a round
//           react        - player button (synchronized, debounced)
//           tick         - one-clock pulse every TICK_DIV clocks
//           time_out     - one-clock pulse at the end of the delay (or on a false start)
//           react_ms     - reaction time in ms, 0 on a false start, MAX_MS on no response
//           result_valid - level, react_ms / false_start valid
//           false_start  - level, react seen during the delay
//           busy         - high in DELAY and MEASURE
module reaction_timer #(
   parameter int unsigned TICK_DIV     = 25_000_000,
   parameter int unsigned MS_DIV       = 50_000,
   parameter int unsigned MIN_DELAY_MS = 500,
   parameter int unsigned RAND_BITS    = 11,
   parameter int unsigned MAX_MS       = 9999
) (
   input logic             clk,
   input logic             rst_n,
   reaction_timer_if.slave bus
);

   localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned MsW    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   // Wide enough for MIN_DELAY_MS + 2**RAND_BITS - 1.
   localparam int unsigned DelayW = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS));

   localparam logic [TickW-1:0]  TickMax  = TickW'(TICK_DIV - 1);
   localparam logic [MsW-1:0]    MsMax    = MsW'(MS_DIV - 1);
   localparam logic [DelayW-1:0] MinDelay = DelayW'(MIN_DELAY_MS);
   localparam logic [13:0]       MaxMs    = 14'(MAX_MS);
   localparam logic [15:0]       LfsrSeed = 16'hACE1;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StDelay   = 2'd1;
   localparam logic [1:0] StMeasure = 2'd2;
   localparam logic [1:0] StDone    = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              start_d_q, start_d_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
   logic              tick_q, tick_d;
   logic [MsW-1:0]    ms_cnt_q, ms_cnt_d;
   logic [DelayW-1:0] delay_cnt_q, delay_cnt_d;
   logic [13:0]       meas_cnt_q, meas_cnt_d;
   logic [13:0]       react_ms_q, react_ms_d;
   logic              result_valid_q, result_valid_d;
   logic              false_start_q, false_start_d;
   logic              time_out_q, time_out_d;
   logic              busy_q, busy_d;

   logic              arm;
   logic              ms_tick;
   logic              ms_clr;
   logic [DelayW-1:0] rand_ext;

   always_comb begin
      state_d        = state_q;
      start_d_d      = bus.start_delay;
      lfsr_d         = lfsr_q;
      delay_cnt_d    = delay_cnt_q;
      meas_cnt_d     = meas_cnt_q;
      react_ms_d     = react_ms_q;
      result_valid_d = result_valid_q;
      false_start_d  = false_start_q;
      time_out_d     = 1'b0;
      ms_clr         = 1'b0;

      arm     = bus.start_delay & ~start_d_q;
      ms_tick = (ms_cnt_q == MsMax);

      rand_ext                 = '0;
      rand_ext[RAND_BITS-1:0]  = lfsr_q[RAND_BITS-1:0];

      // Free-running prescaler; tick_q is high exactly while the count sits at TICK_DIV-1.
      tick_cnt_d = (tick_cnt_q == TickMax) ? '0 : tick_cnt_q + TickW'(1);
      tick_d     = (tick_cnt_d == TickMax);

      if (bus.en_lfsr) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end

      case (state_q)
         StIdle, StDone: begin
            if (arm) begin
               // Uses the LFSR value from before this edge's step.
               delay_cnt_d    = MinDelay + rand_ext;
               react_ms_d     = '0;
               result_valid_d = 1'b0;
               false_start_d  = 1'b0;
               ms_clr         = 1'b1;
               state_d        = StDelay;
            end
         end
         StDelay: begin
            // A press during the delay wins over expiry in the same cycle.
            if (bus.react) begin
               false_start_d  = 1'b1;
               react_ms_d     = '0;
               result_valid_d = 1'b1;
               time_out_d     = 1'b1;
               ms_clr         = 1'b1;
               state_d        = StDone;
            end else if (ms_tick) begin
               delay_cnt_d = delay_cnt_q - DelayW'(1);
               if (delay_cnt_q == DelayW'(1)) begin
                  time_out_d = 1'b1;
                  ms_clr     = 1'b1;
                  meas_cnt_d = '0;
                  state_d    = StMeasure;
               end
            end
         end
         StMeasure: begin
            if (bus.react) begin
               react_ms_d     = meas_cnt_q;
               result_valid_d = 1'b1;
               state_d        = StDone;
            end else if (ms_tick) begin
               meas_cnt_d = meas_cnt_q + 14'd1;
               if (meas_cnt_d == MaxMs) begin
                  react_ms_d     = MaxMs;
                  result_valid_d = 1'b1;
                  state_d        = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      ms_cnt_d = ms_tick ? '0 : ms_cnt_q + MsW'(1);
      if (ms_clr) begin
         ms_cnt_d = '0;
      end

      busy_d = (state_d == StDelay) || (state_d == StMeasure);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         start_d_q      <= 1'b0;
         lfsr_q         <= LfsrSeed;
         tick_cnt_q     <= '0;
         tick_q         <= 1'b0;
         ms_cnt_q       <= '0;
         delay_cnt_q    <= '0;
         meas_cnt_q     <= '0;
         react_ms_q     <= '0;
         result_valid_q <= 1'b0;
         false_start_q  <= 1'b0;
         time_out_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         start_d_q      <= start_d_d;
         lfsr_q         <= lfsr_d;
         tick_cnt_q     <= tick_cnt_d;
         tick_q         <= tick_d;
         ms_cnt_q       <= ms_cnt_d;
         delay_cnt_q    <= delay_cnt_d;
         meas_cnt_q     <= meas_cnt_d;
         react_ms_q     <= react_ms_d;
         result_valid_q <= result_valid_d;
         false_start_q  <= false_start_d;
         time_out_q     <= time_out_d;
         busy_q         <= busy_d;
      end
   end

   assign bus.tick         = tick_q;
   assign bus.time_out     = time_out_q;
   assign bus.react_ms     = react_ms_q;
   assign bus.result_valid = result_valid_q;
   assign bus.false_start  = false_start_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: self-checking bench for reaction_timer with small prescalers.
// A table of rounds is applied; each round pushes its expected outcome to a scoreboard,
// and a monitor pops and compares it when the DUT raises result_valid.
module tb_reaction_timer;
   localparam int MsDiv    = 4;
   localparam int TickDiv  = 8;
   localparam int MinDelay = 2;
   localparam int RandBits = 2;
   localparam int MaxMs    = 20;

   // rmode: 0 = r is cycles after the arming edge, 1 = r is cycles after time_out, 2 = no react
   typedef struct {
      int steps;
      int r;
      int rmode;
      int rearm;
   } vec_t;

   typedef struct {
      int to_cyc;
      int done_cyc;
      int ms;
      int fs;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   reaction_timer_if rt_if ();

   reaction_timer #(
      .TICK_DIV    (TickDiv),
      .MS_DIV      (MsDiv),
      .MIN_DELAY_MS(MinDelay),
      .RAND_BITS   (RandBits),
      .MAX_MS      (MaxMs)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (rt_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_bad    = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   bit          to_seen  = 1'b0;
   bit          rv_prev  = 1'b0;
   logic [15:0] lfsr_m   = 16'hACE1;
   vec_t        vecs[10];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, " time_out"}, int'(rt_if.time_out), 0);
      check({tag, " result_valid"}, int'(rt_if.result_valid), 0);
      check({tag, " false_start"}, int'(rt_if.false_start), 0);
      check({tag, " busy"}, int'(rt_if.busy), 0);
      check({tag, " react_ms"}, int'(rt_if.react_ms), 0);
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rt_if.time_out) begin
               if (sb.size() == 0) begin
                  check("unexpected time_out", int'(rt_if.time_out), 0);
               end else begin
                  check("time_out cycle", cyc, sb[0].to_cyc);
                  to_seen = 1'b1;
               end
            end
            if (rt_if.result_valid && !rv_prev) begin
               if (sb.size() == 0) begin
                  check("unexpected result_valid", int'(rt_if.result_valid), 0);
               end else begin
                  mon_e = sb.pop_front();
                  check("result cycle", cyc, mon_e.done_cyc);
                  check("react_ms", int'(rt_if.react_ms), mon_e.ms);
                  check("false_start", int'(rt_if.false_start), mon_e.fs);
                  check("busy at result", int'(rt_if.busy), 0);
                  check("time_out seen in round", int'(to_seen), 1);
                  to_seen = 1'b0;
               end
            end
         end
         rv_prev = rt_if.result_valid;
      end
   end

   task automatic run_round(input int steps, input int r_in, input int rmode, input int rearm);
      int   d;
      int   t;
      int   r;
      int   k;
      int   e_cyc;
      int   bound;
      exp_t x;
      if (steps > 0) begin
         rt_if.en_lfsr = 1'b1;
         for (int i = 0; i < steps; i++) begin
            step(1);
            lfsr_m = lfsr_next(lfsr_m);
         end
         rt_if.en_lfsr = 1'b0;
      end
      d = MinDelay + int'(lfsr_m[RandBits-1:0]);
      t = MsDiv * d;
      r = (rmode == 2) ? -1 : ((rmode == 1) ? t + r_in : r_in);
      rt_if.start_delay = 1'b1;
      e_cyc = cyc + 1;
      if (r >= 1 && r <= t) begin
         x.to_cyc   = e_cyc + r;
         x.done_cyc = e_cyc + r;
         x.ms       = 0;
         x.fs       = 1;
      end else begin
         x.to_cyc = e_cyc + t;
         x.fs     = 0;
         k        = r - t;
         if (r < 0 || k > MsDiv * MaxMs) begin
            x.ms       = MaxMs;
            x.done_cyc = e_cyc + t + MsDiv * MaxMs;
         end else begin
            x.ms       = (k - 1) / MsDiv;
            x.done_cyc = e_cyc + r;
         end
      end
      sb.push_back(x);
      step(1);
      check("busy after arm", int'(rt_if.busy), 1);
      check("result_valid cleared by arm", int'(rt_if.result_valid), 0);
      check("false_start cleared by arm", int'(rt_if.false_start), 0);
      bound = e_cyc + t + MsDiv * MaxMs + 10;
      while (sb.size() > 0 && cyc < bound) begin
         rt_if.react       = (cyc == e_cyc + r - 1);
         rt_if.start_delay = (rearm > 0 && cyc == e_cyc + rearm - 1);
         step(1);
      end
      rt_if.react       = 1'b0;
      rt_if.start_delay = 1'b0;
      check("round completes within budget", sb.size(), 0);
      sb.delete();
      step(3);
      check("result_valid held", int'(rt_if.result_valid), 1);
      check("react_ms held", int'(rt_if.react_ms), x.ms);
      check("busy low in DONE", int'(rt_if.busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rt_if.en_lfsr     = 1'b0;
      rt_if.start_delay = 1'b0;
      rt_if.react       = 1'b0;

      vecs[0] = '{steps: 0,  r: 9,  rmode: 1, rearm: 0};   // seed, D=3, react_ms 2
      vecs[1] = '{steps: 0,  r: 5,  rmode: 0, rearm: 0};   // false start mid-delay
      vecs[2] = '{steps: 2,  r: 0,  rmode: 1, rearm: 0};   // react on the expiry edge
      vecs[3] = '{steps: 7,  r: 1,  rmode: 1, rearm: 0};   // first MEASURE cycle -> 0
      vecs[4] = '{steps: 4,  r: 80, rmode: 1, rearm: 0};   // last cycle before saturation
      vecs[5] = '{steps: 1,  r: 4,  rmode: 1, rearm: 0};
      vecs[6] = '{steps: 6,  r: 5,  rmode: 1, rearm: 0};   // just past the first ms_tick
      vecs[7] = '{steps: 11, r: 1,  rmode: 0, rearm: 0};   // press in the first DELAY cycle
      vecs[8] = '{steps: 5,  r: 30, rmode: 1, rearm: 2};   // re-arm during DELAY ignored
      vecs[9] = '{steps: 3,  r: 0,  rmode: 2, rearm: 40};  // no response, re-arm in MEASURE

      // Reset state.
      @(posedge clk);
      #1;
      check_all_zero("reset");
      check("reset tick", int'(rt_if.tick), 0);
      #5 rst_n = 1'b1;

      // Tick prescaler after release.
      for (int k = 1; k <= 3 * TickDiv; k++) begin
         step(1);
         check("tick", int'(rt_if.tick), (k % TickDiv == TickDiv - 1) ? 1 : 0);
         check("idle busy", int'(rt_if.busy), 0);
         check("idle time_out", int'(rt_if.time_out), 0);
      end

      for (int i = 0; i < 10; i++) begin
         run_round(vecs[i].steps, vecs[i].r, vecs[i].rmode, vecs[i].rearm);
      end

      // Fresh reset, one LFSR step -> D = 5.
      rst_n = 1'b0;
      #1;
      check_all_zero("reset from DONE");
      lfsr_m = 16'hACE1;
      step(2);
      rst_n = 1'b1;
      run_round(1, 1, 1, 0);

      // Async reset mid-DELAY: outputs drop without a clock edge, no time_out afterwards.
      rt_if.start_delay = 1'b1;
      step(1);
      rt_if.start_delay = 1'b0;
      step(7);
      check("busy mid-DELAY", int'(rt_if.busy), 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("async reset");
      check("async reset tick", int'(rt_if.tick), 0);
      sb.delete();
      lfsr_m = 16'hACE1;
      step(2);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step(1);
         check("no time_out after abort", int'(rt_if.time_out), 0);
      end
      check_all_zero("after abort");

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule

// File: doc/reaction_timer.md
# reaction_timer

Random-delay and reaction-measurement engine that sits on the other end of the light-sequence FSM's handshake. It supplies the FSM's `tick`, runs an LFSR while `en_lfsr` is high, and arms a random millisecond delay on the rising edge of `start_delay`. When the delay expires it pulses `time_out`, then measures the player's reaction time in milliseconds and flags false starts.

## Interface
- `TICK_DIV`, 25_000_000: clocks per `tick` pulse, which is the FSM light step.
- `MS_DIV`, 50_000: clocks per millisecond.
- `MIN_DELAY_MS`, 500: minimum random delay in ms. Must be ≥1.
- `RAND_BITS`, 11: number of LFSR LSBs added to the minimum delay.
- `MAX_MS`, 9999: reaction-counter saturation value. Must fit in 14 bits.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en_lfsr` in 1: while high, the LFSR advances one step every clock.
- `start_delay` in 1: level from the FSM; its 0→1 transition arms a round.
- `react` in 1: player button, already synchronized and debounced, active high.
- `tick` out 1: one-clock pulse every `TICK_DIV` clocks.
- `time_out` out 1: one-clock pulse marking the end of the delay.
- `react_ms` out 14: measured reaction time in ms; 0 on a false start.
- `result_valid` out 1: level; high while `react_ms` / `false_start` are valid.
- `false_start` out 1: level; `react` was seen during the delay.
- `busy` out 1: high in DELAY and MEASURE.

## Operation
- **Reset:** all outputs 0, state IDLE, counters 0, `start_d` 0, LFSR = 16'hACE1.
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Step: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - Never reaches zero.
  - Advances whenever `en_lfsr` is high, in any state.
- **Tick prescaler:** free-running from reset; `tick` is high when the count equals `TICK_DIV-1`, then the count wraps to 0.
- **ms prescaler:** `ms_tick` is high when `ms_cnt == MS_DIV-1`, then wraps. It is cleared to 0 on every arm and on every `time_out`.
- **Edge detect:** `arm = start_delay & ~start_d`, where `start_d` is `start_delay` registered.
- **States:** IDLE, DELAY, MEASURE, DONE.
- **IDLE or DONE + `arm`:**
  - Load `delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]`, using the LFSR value before this edge's update.
  - Clear `react_ms`, `result_valid` and `false_start`.
  - Clear the ms prescaler; go to DELAY.
- **DELAY:**
  - If `react` is high: set `false_start`=1, `react_ms`=0, `result_valid`=1; pulse `time_out`; go to DONE. This has priority over expiry in the same cycle.
  - Else on `ms_tick`: decrement `delay_cnt`. If the old value was 1, pulse `time_out`, clear the ms prescaler and `meas_cnt`, and go to MEASURE.
- **MEASURE:**
  - If `react` is high: `react_ms` = `meas_cnt`, `result_valid`=1, go to DONE.
  - Else on `ms_tick`: `meas_cnt++`. Reaching `MAX_MS` latches `react_ms`=`MAX_MS`, sets `result_valid`, and goes to DONE (no response).
- **`arm` in DELAY or MEASURE:** ignored; the round continues.
- **DONE:** results held until the next `arm`.
- **`rst_n` low mid-round:** immediate return to reset values. No `time_out` is issued for the aborted round.

## Timing
- All outputs are registered.
- **`time_out` after arming:** with arming edge E and loaded delay D, `time_out` is high for exactly the cycle following edge E + D·`MS_DIV`.
- **False-start `time_out`:** `time_out`, `false_start` and `result_valid` all rise on the edge after `react` is sampled high in DELAY.
- **Reaction count:** `react_ms` equals the number of whole `ms_tick`s between the `time_out` edge and the `react` sample edge. `react` sampled in the first MEASURE cycle gives 0.
- **`result_valid`:** rises the clock after `react` is sampled and falls on the edge after `arm`.
- **`busy`:** rises the edge after `arm` and falls on entry to DONE.

## Test plan
Bench parameters: `MS_DIV`=4, `TICK_DIV`=8, `MIN_DELAY_MS`=2, `RAND_BITS`=2, `MAX_MS`=20.
- **Tick and reset:** release reset and hold `en_lfsr`=0 → `tick` pulses at cycles 7, 15, 23, …; every other output stays 0.
- **Nominal delay:** with the LFSR at its seed (lsbs 01, so D=3), raise `start_delay` at edge E → `time_out` is a single pulse following edge E+12, and `busy` is high from E+1.
- **Reaction measurement:** after `time_out`, assert `react` 9 clocks later → `react_ms`=2, `result_valid`=1, `false_start`=0, `busy`=0.
- **False start:** arm, then pulse `react` 5 cycles into DELAY → `time_out` and `false_start` are high the next cycle, `react_ms`=0, and the state is DONE.
- **No response and re-arm:** never assert `react` → `react_ms`=20 and `result_valid`=1 after 80 MEASURE clocks. A second `start_delay` rise mid-MEASURE is ignored; a new rise in DONE clears `result_valid`.
- **LFSR and async reset:** hold `en_lfsr` for 1 cycle → lfsr = 16'h59C3 and D = 2+3 = 5. Pull `rst_n` low mid-DELAY → all outputs 0 with no clock edge, and no `time_out` follows.
